// File: rtl/mul_pkg.sv
// Shared multiplier/divider definitions: FSM states, widths and sign helpers.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 16;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} mul_state_e;

    typedef logic [MUL_WIDTH-1:0]   op_t;
    typedef logic [2*MUL_WIDTH-1:0] prod_t;

    // Magnitude as unsigned; the most negative value maps to 2^(MUL_WIDTH-1).
    function automatic op_t abs_op(input op_t x);
        return x[MUL_WIDTH-1] ? (~x + op_t'(1)) : x;
    endfunction

    function automatic prod_t neg_prod(input prod_t x);
        return ~x + prod_t'(1);
    endfunction

endpackage

// File: rtl/mul_16_step.sv
// One radix-2 iteration: conditionally adds the multiplicand, shifted by the
// iteration index, into the double-width accumulator.
module mul_16_step
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [MUL_CNT_W-1:0] shamt,
    input  logic                 add_en,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [2*WIDTH-1:0] addend;

    always_comb begin
        addend   = {{WIDTH{1'b0}}, mcand} << shamt;
        acc_next = add_en ? (acc + addend) : acc;
    end

endmodule

// File: rtl/mul_16.sv
// Sequential signed shift-add multiplier, fixed 17-clock latency after start.
// Define MUL_OVF_EN to add the overflow output (product exceeds WIDTH-bit signed range).
module mul_16
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
`ifdef MUL_OVF_EN
    ,
    output logic               overflow
`endif
);

    mul_state_e           state_q, state_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     bits_q, bits_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 sign_q, sign_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef MUL_OVF_EN
    logic                 ovf_q, ovf_d;
    logic [WIDTH:0]       prod_hi;
`endif

    mul_16_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
        .shamt    (cnt_q),
        .add_en   (bits_q[0]),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        bits_d    = bits_q;
        acc_d     = acc_q;
        product_d = product_q;
        sign_d    = sign_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef MUL_OVF_EN
        ovf_d     = ovf_q;
        prod_hi   = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = abs_op(multiplicand);
                    bits_d  = abs_op(multiplier);
                    sign_d  = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef MUL_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d  = acc_step;
                bits_d = bits_q >> 1;
                cnt_d  = cnt_q + MUL_CNT_W'(1);
                if (cnt_q == MUL_CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                product_d = sign_q ? neg_prod(acc_q) : acc_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
`ifdef MUL_OVF_EN
                // Fits WIDTH-bit signed only if the top WIDTH+1 bits are all equal.
                prod_hi   = product_d[2*WIDTH-1:WIDTH-1];
                ovf_d     = ~((&prod_hi) | ~(|prod_hi));
`endif
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            bits_q    <= '0;
            acc_q     <= '0;
            product_q <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MUL_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            bits_q    <= bits_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MUL_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign product  = product_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef MUL_OVF_EN
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_mul_16.sv
// Scoreboard bench for mul_16: expected products queued at start, checked at done.
`timescale 1ns/1ps
module tb_mul_16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] product;
    logic        busy;
    logic        done;
`ifdef MUL_OVF_EN
    logic        overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0       = 0;
    int exp_q[$];

    mul_16 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
`ifdef MUL_OVF_EN
        ,
        .overflow     (overflow)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit ovf_of(input int p);
        return (p < -32768) || (p > 32767);
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic start_op(input logic signed [15:0] a, input logic signed [15:0] b,
                            input bit track);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        if (track) exp_q.push_back(int'(a) * int'(b));
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic wait_result(output int lat, output int bc, output bit to);
        int t;
        t  = 0;
        bc = 0;
        while (done !== 1'b1 && t < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            t++;
        end
        to  = (done !== 1'b1);
        lat = cyc - e0;
    endtask

    task automatic pop_exp(output int exp, output bit empty);
        empty = (exp_q.size() == 0);
        exp   = empty ? 0 : exp_q.pop_front();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (product !== 32'd0) begin n_fail++; $display("FAIL reset_product got %h want 0", product); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
`ifdef MUL_OVF_EN
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Common result checks, kept inline per test via this macro-free pattern.
    task automatic test_basic(input logic signed [15:0] a, input logic signed [15:0] b,
                              input string name);
        int lat, bc, exp;
        bit to, empty;
        start_op(a, b, 1'b1);
        wait_result(lat, bc, to);
        pop_exp(exp, empty);
        n_checks++; if (to || empty) begin n_fail++; $display("FAIL %s_timeout got done=%b want 1", name, done); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL %s_latency got %0d want 17", name, lat); end
        n_checks++; if (bc !== 17) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 17", name, bc); end
        n_checks++; if ($signed(product) !== exp) begin n_fail++; $display("FAIL %s_product got %0d want %0d", name, $signed(product), exp); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end got %b want 0", name, busy); end
`ifdef MUL_OVF_EN
        n_checks++; if (overflow !== ovf_of(exp)) begin n_fail++; $display("FAIL %s_ovf got %b want %b", name, overflow, ovf_of(exp)); end
`endif
    endtask

    task automatic test_start_ignored;
        int lat, bc, exp;
        bit to, empty;
        start_op(16'sd100, 16'sd5, 1'b1);
        repeat (4) @(negedge clk);
        multiplicand = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(lat, bc, to);
        pop_exp(exp, empty);
        n_checks++; if (to || empty) begin n_fail++; $display("FAIL ignore_timeout got done=%b want 1", done); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL ignore_latency got %0d want 17", lat); end
        n_checks++; if ($signed(product) !== exp) begin n_fail++; $display("FAIL ignore_product got %0d want %0d", $signed(product), exp); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle got done=%b busy=%b want 1 0", done, busy); end
    endtask

    task automatic test_reset_abort;
        start_op(16'sd300, 16'sd300, 1'b0);
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (product !== 32'd0) begin n_fail++; $display("FAIL abort_product got %h want 0", product); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done); end
`ifdef MUL_OVF_EN
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL abort_ovf got %b want 0", overflow); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, done); end
        test_basic(-16'sd2, 16'sd3, "after_abort");
    endtask

    task automatic test_back_to_back;
        int lat, bc, exp;
        bit to, empty;
        test_basic(-16'sd1, 16'sd1, "b2b_first");
        start_op(16'sd127, -16'sd128, 1'b1);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_clear got %b want 0", done); end
        n_checks++; if ($signed(product) !== -1) begin n_fail++; $display("FAIL b2b_hold got %0d want -1", $signed(product)); end
        wait_result(lat, bc, to);
        pop_exp(exp, empty);
        n_checks++; if (to || empty) begin n_fail++; $display("FAIL b2b_timeout got done=%b want 1", done); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL b2b_done_low got %0d want 17", lat); end
        n_checks++; if ($signed(product) !== exp) begin n_fail++; $display("FAIL b2b_product got %0d want %0d", $signed(product), exp); end
        n_checks++; if ($signed(product) !== -16256) begin n_fail++; $display("FAIL b2b_const got %0d want -16256", $signed(product)); end
    endtask

    initial begin
        test_reset();
        test_basic(16'sd7, -16'sd3, "basic");
        test_basic(-16'sd32768, -16'sd32768, "min_min");
        n_checks++; if (product !== 32'h4000_0000) begin n_fail++; $display("FAIL min_min_const got %h want 40000000", product); end
        test_basic(16'sd0, -16'sd1234, "zero");
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
